// File: rtl/watch_cu_if.sv
// Button, UART and tick/edit-field signals between the watch control unit and its surroundings.
// The master side drives buttons and UART bytes. The slave side is the control unit.
interface watch_cu_if;
    logic       btn_mode;
    logic       btn_up;
    logic       btn_down;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       tick_hour_up;
    logic       tick_hour_down;
    logic       tick_min_up;
    logic       tick_min_down;
    logic       tick_sec_up;
    logic       tick_sec_down;
    logic       edit_mode;
    logic [1:0] edit_field;

    modport master (
        output btn_mode, btn_up, btn_down, rx_data, rx_done,
        input  tick_hour_up, tick_hour_down, tick_min_up, tick_min_down,
        input  tick_sec_up, tick_sec_down, edit_mode, edit_field
    );

    modport slave (
        input  btn_mode, btn_up, btn_down, rx_data, rx_done,
        output tick_hour_up, tick_hour_down, tick_min_up, tick_min_down,
        output tick_sec_up, tick_sec_down, edit_mode, edit_field
    );
endinterface

// File: rtl/watch_cu.sv
// Watch control unit: turns debounced buttons and UART command bytes into one-cycle adjust ticks.
// It also runs the RUN/SET edit FSM, with hold-to-repeat and an idle timeout.
module watch_cu #(
    parameter int REPEAT_DELAY  = 50_000_000,
    parameter int REPEAT_PERIOD = 10_000_000,
    parameter int TIMEOUT       = 1_000_000_000
) (
    input  logic     clk,
    input  logic     rst,
    watch_cu_if.slave bus
);
    localparam int RW_RAW = $clog2(REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD);
    localparam int RW     = (RW_RAW < 1) ? 1 : RW_RAW;
    localparam int TW_RAW = $clog2(TIMEOUT);
    localparam int TW     = (TW_RAW < 1) ? 1 : TW_RAW;

    typedef enum logic [1:0] {RUN = 2'd0, SET_HOUR = 2'd1, SET_MIN = 2'd2, SET_SEC = 2'd3} state_t;
    typedef enum logic [1:0] {CMD_MODE, CMD_UP, CMD_DOWN, CMD_RUN} cmd_t;

    state_t        state, state_next;
    logic          prev_mode, prev_up, prev_down;
    logic          edge_mode, edge_up, edge_down, any_edge, both_held, btn_held;
    logic          rep_armed, rep_dir, rep_phase;
    logic          rep_armed_next, rep_dir_next, rep_phase_next;
    logic [RW-1:0] rep_cnt, rep_cnt_next;
    logic          rep_hold, rep_fire, arm;
    logic [TW-1:0] idle_cnt, idle_next;
    logic          timeout_hit;
    logic          pend_valid, pend_valid_next;
    cmd_t          pend_cmd, pend_cmd_next;
    logic [7:0]    rx_upper;
    logic          rx_cmd_valid;
    cmd_t          rx_cmd;
    logic          ev_mode, ev_up, ev_down, ev_run, ev_any, pend_exec;

    assign edge_mode = bus.btn_mode & ~prev_mode;
    assign edge_up   = bus.btn_up   & ~prev_up;
    assign edge_down = bus.btn_down & ~prev_down;
    assign any_edge  = edge_mode | edge_up | edge_down;
    assign both_held = bus.btn_up & bus.btn_down;
    assign btn_held  = bus.btn_mode | bus.btn_up | bus.btn_down;
    assign rep_hold  = rep_armed && (rep_dir ? (bus.btn_up & ~bus.btn_down)
                                             : (bus.btn_down & ~bus.btn_up));
    assign rep_fire  = rep_hold && (rep_cnt == (rep_phase ? RW'(REPEAT_PERIOD - 1)
                                                          : RW'(REPEAT_DELAY - 1)));
    assign ev_any    = ev_mode | ev_up | ev_down | ev_run;

    always_comb begin
        rx_upper     = bus.rx_data;
        rx_cmd_valid = 1'b1;
        rx_cmd       = CMD_MODE;
        if (bus.rx_data >= 8'h61 && bus.rx_data <= 8'h7A)
            rx_upper = bus.rx_data - 8'h20;
        case (rx_upper)
            8'h4D:   rx_cmd = CMD_MODE;
            8'h55:   rx_cmd = CMD_UP;
            8'h44:   rx_cmd = CMD_DOWN;
            8'h52:   rx_cmd = CMD_RUN;
            default: rx_cmd_valid = 1'b0;
        endcase
    end

    // One event per cycle: button edges first, then a repeat pulse, then the pending UART command
    always_comb begin
        ev_mode   = 1'b0;
        ev_up     = 1'b0;
        ev_down   = 1'b0;
        ev_run    = 1'b0;
        pend_exec = 1'b0;
        arm       = 1'b0;
        if (any_edge) begin
            if (edge_mode) begin
                ev_mode = 1'b1;
            end else if (!both_held) begin
                ev_up   = edge_up;
                ev_down = edge_down;
                arm     = (state != RUN);
            end
        end else if (rep_fire) begin
            ev_up   = rep_dir;
            ev_down = ~rep_dir;
        end else if (pend_valid) begin
            pend_exec = 1'b1;
            case (pend_cmd)
                CMD_MODE: ev_mode = 1'b1;
                CMD_UP:   ev_up   = 1'b1;
                CMD_DOWN: ev_down = 1'b1;
                CMD_RUN:  ev_run  = 1'b1;
            endcase
        end
    end

    always_comb begin
        state_next  = state;
        idle_next   = idle_cnt + 1'b1;
        timeout_hit = (state != RUN) && !ev_any && !btn_held
                      && (idle_cnt == TW'(TIMEOUT - 1));
        if (ev_run) begin
            state_next = RUN;
        end else if (ev_mode) begin
            case (state)
                RUN:      state_next = SET_HOUR;
                SET_HOUR: state_next = SET_MIN;
                SET_MIN:  state_next = SET_SEC;
                SET_SEC:  state_next = RUN;
            endcase
        end else if (timeout_hit) begin
            state_next = RUN;
        end
        if (state == RUN || ev_any || btn_held || timeout_hit)
            idle_next = '0;
    end

    always_comb begin
        rep_armed_next  = rep_armed;
        rep_dir_next    = rep_dir;
        rep_phase_next  = rep_phase;
        rep_cnt_next    = rep_cnt + 1'b1;
        pend_valid_next = pend_valid;
        pend_cmd_next   = pend_cmd;
        if (arm) begin
            rep_armed_next = 1'b1;
            rep_dir_next   = edge_up;
            rep_phase_next = 1'b0;
            rep_cnt_next   = '0;
        end else if (state_next != state || !rep_hold) begin
            rep_armed_next = 1'b0;
            rep_phase_next = 1'b0;
            rep_cnt_next   = '0;
        end else if (rep_fire) begin
            rep_phase_next = 1'b1;
            rep_cnt_next   = '0;
        end
        if (bus.rx_done && rx_cmd_valid) begin
            pend_valid_next = 1'b1;
            pend_cmd_next   = rx_cmd;
        end else if (pend_exec) begin
            pend_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= RUN;
        else
            state <= state_next;
    end

    // Edge-detect history resets high so a button held through reset never produces an edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_mode  <= 1'b1;
            prev_up    <= 1'b1;
            prev_down  <= 1'b1;
            rep_armed  <= 1'b0;
            rep_dir    <= 1'b0;
            rep_phase  <= 1'b0;
            rep_cnt    <= '0;
            idle_cnt   <= '0;
            pend_valid <= 1'b0;
            pend_cmd   <= CMD_MODE;
        end else begin
            prev_mode  <= bus.btn_mode;
            prev_up    <= bus.btn_up;
            prev_down  <= bus.btn_down;
            rep_armed  <= rep_armed_next;
            rep_dir    <= rep_dir_next;
            rep_phase  <= rep_phase_next;
            rep_cnt    <= rep_cnt_next;
            idle_cnt   <= idle_next;
            pend_valid <= pend_valid_next;
            pend_cmd   <= pend_cmd_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.tick_hour_up   <= 1'b0;
            bus.tick_hour_down <= 1'b0;
            bus.tick_min_up    <= 1'b0;
            bus.tick_min_down  <= 1'b0;
            bus.tick_sec_up    <= 1'b0;
            bus.tick_sec_down  <= 1'b0;
            bus.edit_mode      <= 1'b0;
            bus.edit_field     <= 2'd0;
        end else begin
            bus.tick_hour_up   <= ev_up   && (state == SET_HOUR);
            bus.tick_hour_down <= ev_down && (state == SET_HOUR);
            bus.tick_min_up    <= ev_up   && (state == SET_MIN);
            bus.tick_min_down  <= ev_down && (state == SET_MIN);
            bus.tick_sec_up    <= ev_up   && (state == SET_SEC);
            bus.tick_sec_down  <= ev_down && (state == SET_SEC);
            bus.edit_mode      <= (state_next != RUN);
            bus.edit_field     <= state_next;
        end
    end
endmodule

// File: doc/watch_cu.md
Name: watch_cu

Overview:
Control unit that sits directly upstream of the watch datapath. It converts debounced board buttons and UART command bytes into single-cycle up/down tick pulses for the hour, minute and second counters. An edit-mode FSM selects the field being set; hold-to-repeat and an inactivity timeout return the watch to normal RUN.

Parameters:
REPEAT_DELAY, 50_000_000, cycles a button must be held after its edge before auto-repeat starts (0.5 s at 100 MHz)
REPEAT_PERIOD, 10_000_000, cycles between auto-repeat pulses
TIMEOUT, 1_000_000_000, idle cycles in a SET state before forced return to RUN (10 s)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
btn_mode  input  1  debounced level, mode-advance button
btn_up  input  1  debounced level, increment button
btn_down  input  1  debounced level, decrement button
rx_data  input  8  UART received byte
rx_done  input  1  one-cycle strobe, rx_data valid
tick_hour_up / tick_hour_down  output  1 each  one-cycle hour adjust pulses
tick_min_up / tick_min_down  output  1 each  one-cycle minute adjust pulses
tick_sec_up / tick_sec_down  output  1 each  one-cycle second adjust pulses
edit_mode  output  1  high in any SET state
edit_field  output  2  0=none (RUN), 1=hour, 2=min, 3=sec

Behaviour:
- Reset is asynchronous, active-high, with clock clk. On reset: state=RUN; all tick outputs=0; edit_mode=0; edit_field=0; repeat/timeout counters=0; UART pending=empty.
- Button edge detectors: prev registers reset to 1, so a button held through reset produces no edge. Edge = level 1 and prev 0.
- FSM states: RUN, SET_HOUR, SET_MIN, SET_SEC. A mode event advances RUN→SET_HOUR→SET_MIN→SET_SEC→RUN.
- edit_mode and edit_field are registered from state and change one cycle after the mode event.
- Up/down events are ignored in RUN. In a SET state they produce one pulse on the selected field's up/down output.
- Latency: a tick is high for exactly one cycle, starting at the clk edge after the one where the event is detected.
- Auto-repeat: while exactly one of btn_up/btn_down stays high in a SET state, after REPEAT_DELAY cycles from its edge pulse, emit one pulse, then one every REPEAT_PERIOD cycles.
  - Releasing the button, pressing the other one, or any state change clears the repeat counter.
- Simultaneous buttons:
  - Mode edge together with an up/down edge: mode wins; no tick.
  - btn_up and btn_down both high: no ticks; repeat cleared; the edges are discarded.
- UART commands, accepted on rx_done and case-insensitive:
  - 'M' = mode event.
  - 'U' = up event.
  - 'D' = down event.
  - 'R' = go to RUN from any state, next cycle.
  - Other bytes are ignored.
  - UART events never trigger auto-repeat.
- UART collision handling:
  - A decoded command goes into a 1-entry pending register.
  - It executes in the first cycle with no button edge and no active repeat pulse.
  - A new rx_done while a command is pending overwrites it.
  - Only one event (button or UART) executes per cycle.
- Timeout: in a SET state the idle counter increments each cycle and clears on any executed event or any held button.
  - When it reaches TIMEOUT-1, state goes to RUN and the counter clears.
- Reset mid-operation: any in-flight tick pulse is cleared immediately (async), and the state returns to RUN.
- Counter widths are $clog2 of the respective parameter. No wrap occurs before the compare terminates the count.

Test Plan:
(Bench overrides REPEAT_DELAY=8, REPEAT_PERIOD=4, TIMEOUT=32.)
1. Reset, then pulse btn_mode 3 times (2 cycles high each) → edit_field sequence 1,2,3, then 0 on a 4th press; no tick pulses.
2. In SET_MIN, btn_up high for 1 edge → tick_min_up high for exactly 1 cycle, 1 clk after the edge; other ticks 0.
3. In SET_HOUR, hold btn_down for 20 cycles → tick_hour_down pulses at edge+1, edge+9, edge+13, edge+17 (4 pulses); pressing btn_up mid-hold stops repeats.
4. In RUN, send rx_data 'u' → no tick. Send 'm' then 'U' → state SET_HOUR, tick_hour_up one pulse. Send 'r' → edit_field=0 next cycle.
5. rx_done 'D' in the same cycle as a btn_mode edge while in SET_SEC → mode executes (RUN); the pending 'D' then runs in RUN and is ignored. Repeat starting in SET_MIN → state SET_SEC and one tick_sec_down one cycle later.
6. Enter SET_SEC, idle 32 cycles → edit_field returns to 0. Assert rst while btn_up is held in SET_MIN → RUN with all outputs 0, and no tick after deassert until btn_up is released and pressed again.
